// File: rtl/rr_channel_mux.sv
// rr_channel_mux: 4-to-1 round-robin collector, tags each beat with its source channel.
// Latency: 1 cycle, in_valid to out_valid (one registered output stage).
// Backpressure: in_ready is all-zero while the output is full and out_ready=0; drain+reload with no bubble.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_data[4*WIDTH]      ch i data at [i*WIDTH +: WIDTH] (ch0=W .. ch3=Z)
//   in_valid[4]           per-channel request
//   in_ready[4]           per-channel accept, one-hot or zero
//   out_data, out_sel     registered beat and its source index
//   out_valid, out_ready  output handshake
module rr_channel_mux #(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             load_en;
  logic             gnt_found;
  logic [1:0]       gnt_idx;
  logic [1:0]       cand;
  logic [WIDTH-1:0] ch_dat [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_dat[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register can take a new beat when empty or draining this cycle.
  assign load_en = ~out_valid_q | out_ready;

  // Search from ptr upward, wrapping mod 4; first requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Ready is held low during reset so no beat is consumed that the reset then drops.
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load_en && gnt_found) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (gnt_found) begin
        out_valid_d = 1'b1;
        out_data_d  = ch_dat[gnt_idx];
        out_sel_d   = gnt_idx;
        ptr_d       = gnt_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      ptr_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_channel_mux.sv
// tb_rr_channel_mux: directed scenarios plus randomized traffic against a cycle-level reference model.
// Latency: n/a (testbench).
// Backpressure: out_ready driven randomly; fairness bound tracked per channel.
module tb_rr_channel_mux;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [1:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the output register should hold.
  bit m_known = 0;
  int m_vld, m_data, m_sel, m_ptr;
  int waits [4];

  rr_channel_mux #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check combinational ready and registered outputs,
  // then advance the model across the rising edge.
  task automatic cycle(input bit r, input logic [3:0] v, input logic [7:0] d, input bit ordy);
    bit load;
    int g;
    int c;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    load = (m_vld == 0) || ordy;
    g = -1;
    if (!r && load) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (v[c] && g < 0) g = c;
      end
    end
    chk("in_ready", in_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    if (m_known) begin
      chk("out_valid", out_valid, m_vld);
      if (m_vld != 0 || r) begin
        chk("out_data", out_data, m_data);
        chk("out_sel", out_sel, m_sel);
      end
    end
    @(posedge clk);
    if (r) begin
      m_known = 1; m_vld = 0; m_data = 0; m_sel = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) waits[i] = 0;
    end else begin
      if (g >= 0) begin
        chk("fair_wait", (waits[g] <= 3) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) begin
          if (i == g || !v[i]) waits[i] = 0;
          else waits[i]++;
        end
      end else begin
        for (int i = 0; i < 4; i++) if (!v[i]) waits[i] = 0;
      end
      if (load) begin
        if (g >= 0) begin
          m_vld = 1; m_data = (d >> (2 * g)) & 3; m_sel = g; m_ptr = (g + 1) % 4;
        end else begin
          m_vld = 0;
        end
      end
    end
  endtask

  logic [7:0] rd;
  logic [3:0] rv;
  bit         rr;
  bit         ro;

  initial begin
    rst = 1'b1; in_valid = 4'b0; in_data = 8'h0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) waits[i] = 0;

    // T1: reset with all channels requesting
    cycle(1, 4'b1111, 8'hE4, 1);
    cycle(1, 4'b1111, 8'hE4, 1);
    #1;
    chk("t1_in_ready", in_ready, 4'b0000);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_out_sel", out_sel, 0);
    chk("t1_out_data", out_data, 0);

    // T2: single request on ch2
    cycle(0, 4'b0100, 8'b0011_0000, 1);
    #1;
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, 2'b11);
    chk("t2_out_sel", out_sel, 2);

    // T3: round-robin over all channels from ptr=0
    cycle(1, 4'b0000, 8'h00, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 4'b1111, 8'b11_10_01_00, 1);
      #1;
      chk("t3_out_sel", out_sel, k % 4);
      chk("t3_out_data", out_data, k % 4);
    end

    // T4: backpressure holds output, then drain and reload with no bubble
    for (int k = 0; k < 3; k++) begin
      cycle(0, 4'b1111, 8'b11_10_01_00, 0);
      #1;
      chk("t4_hold_sel", out_sel, 0);
      chk("t4_hold_valid", out_valid, 1);
    end
    cycle(0, 4'b1111, 8'b11_10_01_00, 1);
    #1;
    chk("t4_reload_valid", out_valid, 1);
    chk("t4_reload_sel", out_sel, 1);

    // T5: wrap after grant to ch3
    cycle(1, 4'b0000, 8'h00, 1);
    cycle(0, 4'b1000, 8'b11_10_01_00, 1);
    #1 chk("t5_sel_a", out_sel, 3);
    cycle(0, 4'b1001, 8'b11_10_01_00, 1);
    #1 chk("t5_sel_b", out_sel, 0);
    cycle(0, 4'b1001, 8'b11_10_01_00, 1);
    #1 chk("t5_sel_c", out_sel, 3);

    // T6: reset while a beat is stalled
    cycle(0, 4'b0010, 8'b11_10_01_00, 0);
    #1 chk("t6_stalled_valid", out_valid, 1);
    cycle(1, 4'b1111, 8'b11_10_01_00, 0);
    #1 chk("t6_dropped_valid", out_valid, 0);
    cycle(0, 4'b1111, 8'b11_10_01_00, 1);
    #1;
    chk("t6_first_sel", out_sel, 0);
    chk("t6_first_valid", out_valid, 1);

    // Random traffic; pending senders keep their data stable.
    rd = 8'h00; rv = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(rv[i] && !in_ready[i])) begin
          rd[2*i +: 2] = 2'($urandom_range(0, 3));
        end
      end
      rv = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) rv = rv | in_valid;
      rr = ($urandom_range(0, 99) < 2);
      ro = ($urandom_range(0, 99) < 70);
      cycle(rr, rv, rd, ro);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
